// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the accumulator-ALU arbiter slice.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: ALU_* operation codes, ARB_* sequencer state encodings,
// op_is_err() which decides whether a request is rejected without touching the ALU.
package alu_arbiter_pkg;

  // Operation codes understood by the accumulator ALU. 5..7 are unused.
  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_DIV  = 3'd3;
  localparam logic [2:0] ALU_MOD  = 3'd4;

  // Sequencer states.
  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_LOAD = 3'd1,
    ARB_EXEC = 3'd2,
    ARB_CAPT = 3'd3,
    ARB_RESP = 3'd4
  } arb_state_t;

  // A request is rejected outright when the opcode is unknown or when it
  // would divide by zero; such requests never reach the ALU.
  function automatic logic op_is_err(input logic [2:0] op, input logic b_zero);
    return (op > ALU_MOD) || (((op == ALU_DIV) || (op == ALU_MOD)) && b_zero);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, response lines and ALU control/result lines.
// Latency: n/a (wiring only).
// Backpressure: requests use valid/ready; responses are unconditional pulses.
//
// Modports:
//   slave  - the arbiter: consumes requests and alu_dout, drives ready/rsp/alu_*.
//   master - the environment: requesters plus the ALU itself.
interface alu_arbiter_if #(
  parameter int DW = 8
) ();

  logic          req0_valid;
  logic          req0_ready;
  logic [2:0]    req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;

  logic          req1_valid;
  logic          req1_ready;
  logic [2:0]    req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;

  logic          rsp0_valid;
  logic          rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic [2:0]    alu_op;
  logic [DW-1:0] alu_bus;
  logic          alu_wen;
  logic          alu_inc;
  logic          alu_rst;
  logic [DW-1:0] alu_dout;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output alu_op, alu_bus, alu_wen, alu_inc, alu_rst,
    input  alu_dout
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  alu_op, alu_bus, alu_wen, alu_inc, alu_rst,
    output alu_dout
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant with a remembered last winner.
// Latency: grant is combinational from req; last_grant updates on the clock after update.
// Backpressure: none; the caller decides when a grant is consumed (update).
//
// Ports: Clk, RST (sync, active-high); req[1:0] requests in; update marks the
// grant as taken; grant_vld/grant_idx give the current winner.
module rr_arb2 #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_vld,
  output logic       grant_idx
);

  localparam logic FIRST_IDX = FIRST_PRIO[0];

  logic last_grant;

  // With a single requester it wins outright; on contention the one that
  // did not win last time goes first.
  always_comb begin
    grant_vld = |req;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req[1];
    end
  end

  // Reset value makes FIRST_PRIO the winner of the first contention.
  always_ff @(posedge Clk) begin
    if (RST) begin
      last_grant <= ~FIRST_IDX;
    end else if (update) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto the shared accumulator ALU and sequences load/exec/capture.
// Latency: accept->response 4 cycles (arith), 3 (NONE), 1 (rejected op); one idle cycle between jobs.
// Backpressure: requesters stall on ready while a job is in flight; responses cannot be stalled.
//
// Ports: Clk, RST (sync, active-high); bus (alu_arbiter_if.slave) carries both
// request handshakes, the shared response lines and the ALU control/result lines.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIRST_PRIO = 0
) (
  input  logic         Clk,
  input  logic         RST,
  alu_arbiter_if.slave bus
);

  arb_state_t    state;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          owner_q;

  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;

  logic [1:0]    req_vec;
  logic          grant_vld;
  logic          grant_idx;
  logic          accept;

  logic [2:0]    sel_op;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;

  assign req_vec = {bus.req1_valid, bus.req0_valid};

  rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_rr_arb2 (
    .Clk      (Clk),
    .RST      (RST),
    .req      (req_vec),
    .update   (accept),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx)
  );

  // Accept only from IDLE; RST masks ready so nothing is taken in a reset cycle.
  assign accept         = (state == ARB_IDLE) && grant_vld && !RST;
  assign bus.req0_ready = accept && !grant_idx;
  assign bus.req1_ready = accept &&  grant_idx;

  assign sel_op = grant_idx ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant_idx ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant_idx ? bus.req1_b  : bus.req0_b;

  always_ff @(posedge Clk) begin
    if (RST) begin
      state        <= ARB_IDLE;
      op_q         <= ALU_NONE;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // Response valids are single-cycle: set only on the edge into RESP.
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            owner_q <= grant_idx;
            if (op_is_err(sel_op, sel_b == '0)) begin
              rsp_err_q    <= 1'b1;
              rsp_data_q   <= '0;
              rsp0_valid_q <= !grant_idx;
              rsp1_valid_q <=  grant_idx;
              state        <= ARB_RESP;
            end else begin
              state <= ARB_LOAD;
            end
          end
        end
        ARB_LOAD: begin
          // A pure load needs no execute step; the accumulator already holds A.
          state <= (op_q == ALU_NONE) ? ARB_CAPT : ARB_EXEC;
        end
        ARB_EXEC: begin
          state <= ARB_CAPT;
        end
        ARB_CAPT: begin
          rsp_data_q   <= bus.alu_dout;
          rsp_err_q    <= 1'b0;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <=  owner_q;
          state        <= ARB_RESP;
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  // ALU control decode. The accumulator is held cleared while idle so one
  // requester's result can never be observed by the next.
  always_comb begin
    bus.alu_op  = ALU_NONE;
    bus.alu_bus = '0;
    bus.alu_wen = 1'b0;
    bus.alu_inc = 1'b0;
    bus.alu_rst = RST || (state == ARB_IDLE);
    case (state)
      ARB_LOAD: begin
        bus.alu_wen = 1'b1;
        bus.alu_bus = a_q;
      end
      ARB_EXEC: begin
        bus.alu_op  = op_q;
        bus.alu_bus = b_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model.
// Drives and samples on the falling edge; includes an accumulator ALU model.
// Directed requests from the test plan are queued ahead of random traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW   = 8;
  localparam int NCYC = 3000;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  logic Clk = 1'b0;
  logic RST;

  always #5 Clk = ~Clk;

  alu_arbiter_if #(.DW(DW)) u_if ();

  alu_arbiter #(
    .DW        (DW),
    .FIRST_PRIO(0)
  ) u_dut (
    .Clk(Clk),
    .RST(RST),
    .bus(u_if)
  );

  // Accumulator ALU: clear, load, or apply op with the bus operand.
  logic [DW-1:0] acc;
  assign u_if.alu_dout = acc;

  always @(posedge Clk) begin
    if (u_if.alu_rst) begin
      acc <= '0;
    end else if (u_if.alu_wen) begin
      acc <= u_if.alu_bus;
    end else begin
      case (u_if.alu_op)
        ALU_ADD: acc <= 8'((int'(acc) + int'(u_if.alu_bus)) % 256);
        ALU_MUL: acc <= 8'((int'(acc) * int'(u_if.alu_bus)) % 256);
        ALU_DIV: if (u_if.alu_bus != 0) acc <= acc / u_if.alu_bus;
        ALU_MOD: if (u_if.alu_bus != 0) acc <= acc % u_if.alu_bus;
        default: begin end
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outcome of one request, straight from the arithmetic rules.
  function automatic void ref_result(input req_t r, output logic [7:0] d, output logic e);
    e = 1'b0;
    d = 8'h00;
    case (r.op)
      ALU_NONE: d = r.a;
      ALU_ADD:  d = 8'((int'(r.a) + int'(r.b)) % 256);
      ALU_MUL:  d = 8'((int'(r.a) * int'(r.b)) % 256);
      ALU_DIV:  if (r.b == 0) e = 1'b1; else d = r.a / r.b;
      ALU_MOD:  if (r.b == 0) e = 1'b1; else d = r.a % r.b;
      default:  e = 1'b1;
    endcase
  endfunction

  task automatic new_req(output req_t r);
    if ($urandom_range(0, 5) == 0) r.op = 3'($urandom_range(5, 7));
    else r.op = 3'($urandom_range(0, 4));
    r.a = 8'($urandom);
    r.b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
  endtask

  req_t dq0[$];
  req_t dq1[$];
  req_t pend_req[2];
  bit   pend[2];

  // Reference-model state: the one job in flight, its accept cycle and latency.
  bit         active;
  int         acc_cyc;
  int         lat;
  int         k;
  req_t       cur;
  logic       cur_own;
  logic       m_last;
  bit         rst_hit;
  bit         do_rst;
  int         n_rsp;
  logic       exp_g;
  logic       can;
  logic [7:0] ed;
  logic       ee;
  logic       ex_wen;
  logic       ex_rst;
  logic [2:0] ex_op;
  logic [7:0] ex_bus;

  initial begin
    RST             = 1'b1;
    u_if.req0_valid = 1'b0;
    u_if.req0_op    = '0;
    u_if.req0_a     = '0;
    u_if.req0_b     = '0;
    u_if.req1_valid = 1'b0;
    u_if.req1_op    = '0;
    u_if.req1_a     = '0;
    u_if.req1_b     = '0;
    active  = 1'b0;
    acc_cyc = 0;
    lat     = 0;
    m_last  = 1'b1;
    rst_hit = 1'b0;
    n_rsp   = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    dq0.push_back('{ALU_ADD, 8'h30, 8'h25});
    dq0.push_back('{ALU_DIV, 8'h40, 8'h00});
    dq0.push_back('{ALU_MOD, 8'h17, 8'h05});
    dq1.push_back('{ALU_MUL, 8'h10, 8'h20});
    dq1.push_back('{ALU_MUL, 8'h0F, 8'h11});
    dq1.push_back('{3'd7,    8'h12, 8'h34});

    for (int n = 0; n < NCYC; n++) begin
      @(negedge Clk);

      if (active && (n - acc_cyc) > lat) active = 1'b0;
      k = active ? (n - acc_cyc) : 0;

      if (n == 0) begin
        check_eq("reset_rsp_data", 32'(u_if.rsp_data), 32'h0);
        check_eq("reset_rsp_err", 32'(u_if.rsp_err), 32'h0);
      end

      ex_wen = active && (lat >= 3) && (k == 1);
      ex_bus = (active && lat >= 3 && k == 1) ? cur.a :
               (active && lat == 4 && k == 2) ? cur.b : 8'h00;
      ex_op  = (active && lat == 4 && k == 2) ? cur.op : ALU_NONE;
      ex_rst = !active || RST;

      check_eq("alu_op", 32'(u_if.alu_op), 32'(ex_op));
      check_eq("alu_bus", 32'(u_if.alu_bus), 32'(ex_bus));
      check_eq("alu_wen", 32'(u_if.alu_wen), 32'(ex_wen));
      check_eq("alu_inc", 32'(u_if.alu_inc), 32'h0);
      check_eq("alu_rst", 32'(u_if.alu_rst), 32'(ex_rst));
      check_eq("rsp0_valid", 32'(u_if.rsp0_valid), 32'(active && k == lat && !cur_own));
      check_eq("rsp1_valid", 32'(u_if.rsp1_valid), 32'(active && k == lat && cur_own));
      if (active && k == lat) begin
        ref_result(cur, ed, ee);
        check_eq("rsp_data", 32'(u_if.rsp_data), 32'(ed));
        check_eq("rsp_err", 32'(u_if.rsp_err), 32'(ee));
        n_rsp++;
      end

      // Hold reset for the first cycles, then once more while a job is in EXEC.
      do_rst = (n < 3) || (!rst_hit && n >= 300 && active && lat == 4 && k == 2);
      if (n >= 3 && do_rst) begin
        rst_hit = 1'b1;
        dq1.push_back('{ALU_NONE, 8'hA5, 8'h00});
      end
      RST = do_rst;

      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if (r == 0 && dq0.size() > 0) begin
            pend_req[0] = dq0.pop_front();
            pend[0] = 1'b1;
          end else if (r == 1 && dq1.size() > 0) begin
            pend_req[1] = dq1.pop_front();
            pend[1] = 1'b1;
          end else if ($urandom_range(0, 2) != 0) begin
            new_req(pend_req[r]);
            pend[r] = 1'b1;
          end
        end
      end
      u_if.req0_valid = pend[0];
      u_if.req0_op    = pend[0] ? pend_req[0].op : 3'd0;
      u_if.req0_a     = pend[0] ? pend_req[0].a  : 8'h00;
      u_if.req0_b     = pend[0] ? pend_req[0].b  : 8'h00;
      u_if.req1_valid = pend[1];
      u_if.req1_op    = pend[1] ? pend_req[1].op : 3'd0;
      u_if.req1_a     = pend[1] ? pend_req[1].a  : 8'h00;
      u_if.req1_b     = pend[1] ? pend_req[1].b  : 8'h00;

      #1;
      exp_g = (pend[0] && pend[1]) ? ~m_last : pend[1];
      can   = !active && !do_rst && (pend[0] || pend[1]);
      check_eq("req0_ready", 32'(u_if.req0_ready), 32'(can && !exp_g));
      check_eq("req1_ready", 32'(u_if.req1_ready), 32'(can && exp_g));
      if (do_rst) begin
        check_eq("rst_alu_clear", 32'(u_if.alu_rst), 32'h1);
        active = 1'b0;
        m_last = 1'b1;
      end else if (can) begin
        active  = 1'b1;
        acc_cyc = n;
        cur     = pend_req[exp_g];
        cur_own = exp_g;
        pend[exp_g] = 1'b0;
        m_last  = exp_g;
        ref_result(cur, ed, ee);
        lat = ee ? 1 : ((cur.op == ALU_NONE) ? 3 : 4);
      end
    end

    check_eq("directed0_drained", 32'(dq0.size()), 32'h0);
    check_eq("directed1_drained", 32'(dq1.size()), 32'h0);
    check_eq("mid_op_reset_hit", 32'(rst_hit), 32'h1);
    check_eq("responses_seen", 32'(n_rsp > 200), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 8-bit accumulator ALU. Each requester submits an operation with operands A and B over a valid/ready handshake. The block grants one requester at a time and runs a fixed micro-sequence on the ALU control lines: load A, execute the op with B, capture the result. It returns the result to the owning requester. It sits between the control unit / secondary master and the accumulator ALU, and is the only driver of the ALU control inputs.

Parameters:
DW, 8, datapath width; must match the ALU width.
FIRST_PRIO, 0, requester that wins the first simultaneous request after reset (0 or 1).

Ports:
Clk  in  1  clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a request; payload held stable until accepted.
req0_ready  out  1  requester 0 accepted this cycle.
req0_op  in  3  operation code (shared ALU_* codes).
req0_a  in  DW  operand A.
req0_b  in  DW  operand B.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
rsp0_valid  out  1  one-cycle response pulse to requester 0.
rsp1_valid  out  1  one-cycle response pulse to requester 1.
rsp_data  out  DW  result; valid only while rsp0_valid or rsp1_valid is high.
rsp_err  out  1  error flag; qualified by rsp*_valid.
alu_op  out  3  to ALU op select.
alu_bus  out  DW  to ALU operand bus.
alu_wen  out  1  to ALU write enable.
alu_inc  out  1  to ALU increment; always 0.
alu_rst  out  1  to ALU clear.
alu_dout  in  DW  ALU accumulator output; registered inside the ALU.

Behaviour:
- Reset values: state IDLE; rsp0_valid, rsp1_valid, rsp_err = 0; rsp_data = 0; last_grant = ~FIRST_PRIO. Reset mid-transaction drops it with no response.
- States: IDLE, LOAD, EXEC, CAPT, RESP.
- IDLE
  - Arbitrate combinationally. If exactly one req valid, grant it. If both valid, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && granted N && !RST.
  - On accept: latch op, a, b and owner into registers; update last_grant.
- Next state from IDLE on accept:
  - op in {ADD, MUL, DIV, MOD} with b != 0 → LOAD.
  - op = NONE → LOAD (pure load; result = A).
  - op in {DIV, MOD} with b == 0, or op in 5..7 → RESP with err = 1, data = 0. The ALU is never touched.
- LOAD: alu_op = NONE, alu_wen = 1, alu_bus = a. Next state is EXEC, or CAPT if op = NONE.
- EXEC: alu_op = op, alu_bus = b, alu_wen = 0. Next state CAPT.
- CAPT: rsp_data <= alu_dout, rsp_err <= 0. Next state RESP.
- RESP: rsp<owner>_valid = 1 for exactly this cycle. No backpressure on responses. Next state IDLE.
- Combinational ALU defaults outside LOAD/EXEC: alu_op = NONE, alu_wen = 0, alu_bus = 0, alu_inc = 0.
- alu_rst = 1 when RST or state == IDLE, so the accumulator is cleared between transactions and no data leaks across requesters. It is 0 in LOAD/EXEC/CAPT/RESP.
- Latency, counted from the accept cycle t:
  - Arithmetic op: rsp at t+4.
  - NONE op: rsp at t+3.
  - Error: rsp at t+1.
  - Next accept is possible in the cycle after RESP.
- Results wrap modulo 2^DW: MUL keeps the low DW bits; ADD overflow wraps.
- A requester dropping valid before ready is illegal; the block does not check for it.

Decomposition:
- The ALU_NONE/ADD/MUL/DIV/MOD codes (0..4) stay in the shared define header.
- Arbiter state encodings go in the same header as ARB_* constants.
- One natural sub-module: rr_arb2, the two-way round-robin grant with a last_grant register. Everything else stays in alu_arbiter.

Test Plan:
- Add: req0 ADD a=0x30 b=0x25 accepted at t → alu_wen=1, alu_bus=0x30 at t+1. alu_op=ADD, alu_bus=0x25 at t+2. rsp0_valid at t+4 with rsp_data=0x55, rsp_err=0. rsp1_valid stays 0.
- Multiply wrap: req1 MUL a=0x10 b=0x20 → rsp1_valid with rsp_data=0x00. MUL a=0x0F b=0x11 → rsp_data=0xFF.
- Divide by zero: req0 DIV a=0x40 b=0x00 → rsp0_valid at t+1, rsp_err=1, rsp_data=0x00, alu_wen never high. Then MOD a=0x17 b=0x05 → rsp_data=0x03.
- Contention: both valid from reset, FIRST_PRIO=0 → req0 served, then req1. Both valid again → req0, since last grant was req1. No cycle has both ready signals high.
- Reset mid-op: RST during EXEC → next cycle state IDLE, alu_rst=1, no rsp pulse. A subsequent req1 NONE a=0xA5 → rsp1_valid at t+3 with rsp_data=0xA5.
- Invalid op 7 from req1 → rsp1_valid at t+1, rsp_err=1, rsp_data=0. alu_op stays NONE throughout.
